// File: rtl/app_fifo_if.sv
// Core-port bundle for app_fifo: cs/we/address/write_data from the bus mux,
// read_data/ready back from the core.
interface app_fifo_if;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output cs,
      output we,
      output address,
      output write_data,
      input  read_data,
      input  ready
   );

   modport slave (
      input  cs,
      input  we,
      input  address,
      input  write_data,
      output read_data,
      output ready
   );
endinterface

// File: rtl/app_fifo.sv
// Memory-mapped 32-bit word FIFO (mailbox / staging buffer) with push/pop/peek
// registers, fill status and sticky overflow/underflow flags.
module app_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic      clk,
   input  logic      reset_n,
   app_fifo_if.slave bus
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   localparam logic [7:0] ADDR_NAME0   = 8'h00;
   localparam logic [7:0] ADDR_VERSION = 8'h01;
   localparam logic [7:0] ADDR_CTRL    = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_DATA    = 8'h10;
   localparam logic [7:0] ADDR_PEEK    = 8'h11;

   localparam logic [31:0] NAME0_VALUE   = 32'h61707066;
   localparam logic [31:0] VERSION_VALUE = 32'h00000001;

   logic                  r_cs;
   logic                  r_ready;
   logic [31:0]           r_read_data;
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [31:0]           r_mem [DEPTH];

   logic        w_act;
   logic        w_empty;
   logic        w_full;
   logic        w_push;
   logic        w_pop;
   logic        w_flush;
   logic [7:0]  w_count8;
   logic [31:0] w_status;
   logic [31:0] w_head;
   logic [31:0] w_rd_value;

   // One side effect per access: only the first cs-high cycle is an act.
   assign w_act   = bus.cs && !r_cs;
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH_CNT);
   assign w_push  = w_act &&  bus.we && (bus.address == ADDR_DATA);
   assign w_pop   = w_act && !bus.we && (bus.address == ADDR_DATA);
   assign w_flush = w_act &&  bus.we && (bus.address == ADDR_CTRL) && bus.write_data[0];

   always_comb begin
      w_count8                 = '0;
      w_count8[DEPTH_LOG2:0]   = r_count;
   end

   assign w_status = {16'h0000, w_count8, 4'h0, r_underflow, r_overflow, w_full, w_empty};
   assign w_head   = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];

   always_comb begin
      w_rd_value = '0;
      case (bus.address)
         ADDR_NAME0:   w_rd_value = NAME0_VALUE;
         ADDR_VERSION: w_rd_value = VERSION_VALUE;
         ADDR_STATUS:  w_rd_value = w_status;
         ADDR_DATA:    w_rd_value = w_head;
         ADDR_PEEK:    w_rd_value = w_head;
         default:      w_rd_value = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cs        <= 1'b0;
         r_ready     <= 1'b0;
         r_read_data <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_cs    <= bus.cs;
         r_ready <= bus.cs;

         // read_data holds its value between read acts
         if (w_act && !bus.we)
            r_read_data <= w_rd_value;

         if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else if (w_push) begin
            if (w_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
               r_count  <= r_count + (DEPTH_LOG2+1)'(1);
            end
         end else if (w_pop) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
               r_count  <= r_count - (DEPTH_LOG2+1)'(1);
            end
         end
      end
   end

   // Storage has no reset; flush only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (reset_n && w_push && !w_full)
         r_mem[r_wr_ptr] <= bus.write_data;
   end

   assign bus.ready     = r_ready;
   assign bus.read_data = r_read_data;

endmodule

// File: tb/tb_app_fifo.sv
// Randomized and directed bench for app_fifo, checked against a queue-based
// model of the FIFO and its register map.
module tb_app_fifo;

   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   localparam logic [7:0] A_NAME0   = 8'h00;
   localparam logic [7:0] A_VERSION = 8'h01;
   localparam logic [7:0] A_CTRL    = 8'h08;
   localparam logic [7:0] A_STATUS  = 8'h09;
   localparam logic [7:0] A_DATA    = 8'h10;
   localparam logic [7:0] A_PEEK    = 8'h11;

   logic clk;
   logic reset_n;

   app_fifo_if bus_if();

   app_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [31:0] mq[$];
   bit          m_ov = 1'b0;
   bit          m_uf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [7:0] c;
      c = 8'(mq.size());
      return {16'h0000, c, 4'h0, m_uf, m_ov, (mq.size() == DEPTH), (mq.size() == 0)};
   endfunction

   // One bus access, starting and ending 1 time unit after a rising edge.
   task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rd);
      bus_if.cs = 1'b1;
      bus_if.we = w;
      bus_if.address = a;
      bus_if.write_data = d;
      check("ready_pre", {31'b0, bus_if.ready}, 32'd0);
      @(posedge clk); #1;
      check("ready_post", {31'b0, bus_if.ready}, 32'd1);
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
      end
      rd = bus_if.read_data;
      bus_if.cs = 1'b0;
      bus_if.we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_push(input logic [31:0] d, input int hold);
      logic [31:0] rd;
      access(1'b1, A_DATA, d, hold, rd);
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ov = 1'b1;
   endtask

   task automatic do_pop(input string tag, input int hold);
      logic [31:0] rd;
      logic [31:0] exp;
      access(1'b0, A_DATA, 32'h0, hold, rd);
      if (mq.size() > 0) exp = mq.pop_front();
      else begin
         exp = 32'h0;
         m_uf = 1'b1;
      end
      check(tag, rd, exp);
   endtask

   task automatic do_peek(input string tag, input int hold);
      logic [31:0] rd;
      access(1'b0, A_PEEK, 32'h0, hold, rd);
      check(tag, rd, (mq.size() > 0) ? mq[0] : 32'h0);
   endtask

   task automatic do_status(input string tag, input int hold);
      logic [31:0] rd;
      access(1'b0, A_STATUS, 32'h0, hold, rd);
      check(tag, rd, model_status());
   endtask

   task automatic do_ctrl(input logic [31:0] d, input int hold);
      logic [31:0] rd;
      access(1'b1, A_CTRL, d, hold, rd);
      if (d[0]) begin
         mq.delete();
         m_ov = 1'b0;
         m_uf = 1'b0;
      end
   endtask

   task automatic do_read_const(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      access(1'b0, a, 32'h0, 1, rd);
      check(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] val;
      logic [7:0]  unmapped [4];
      int          op;
      int          hold;

      unmapped[0] = 8'h02;
      unmapped[1] = 8'h20;
      unmapped[2] = 8'hFF;
      unmapped[3] = A_CTRL;

      reset_n = 1'b0;
      bus_if.cs = 1'b0;
      bus_if.we = 1'b0;
      bus_if.address = 8'h00;
      bus_if.write_data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rst_ready", {31'b0, bus_if.ready}, 32'd0);
      check("rst_rdata", bus_if.read_data, 32'd0);
      @(posedge clk); #1;

      // Identification and reset status
      do_read_const("name0", A_NAME0, 32'h61707066);
      do_read_const("version", A_VERSION, 32'h00000001);
      do_read_const("status_rst", A_STATUS, 32'h00000001);

      // Held-cs pushes must not duplicate
      do_push(32'hDEADBEEF, 2);
      do_push(32'h12345678, 2);
      do_read_const("status_cnt2", A_STATUS, 32'h00000200);
      do_peek("peek_head", 2);
      do_read_const("status_after_peek", A_STATUS, 32'h00000200);
      do_pop("pop_1st", 2);
      do_pop("pop_2nd", 1);
      do_read_const("status_empty", A_STATUS, 32'h00000001);

      // Overflow at depth
      for (int i = 0; i <= DEPTH; i++) do_push(32'(i), 1);
      do_read_const("status_full_ov", A_STATUS, 32'h00001006);
      for (int i = 0; i < DEPTH; i++) do_pop("pop_fill", 1);
      do_status("status_drained", 1);

      // Underflow, then flush clears flags
      do_ctrl(32'h1, 1);
      do_pop("pop_empty", 1);
      do_read_const("status_uf", A_STATUS, 32'h00000009);
      do_peek("peek_empty", 1);
      do_ctrl(32'hFFFF_FFFF, 1);
      do_read_const("status_flushed", A_STATUS, 32'h00000001);

      // Pointer wrap, order preserved
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 12; i++) do_push($urandom, 1);
         for (int i = 0; i < 12; i++) do_pop("pop_wrap", 1);
      end
      do_read_const("status_wrap", A_STATUS, 32'h00000001);

      // Writes to read-only / unmapped space have no effect
      access(1'b1, A_NAME0, 32'h0, 1, rd);
      access(1'b1, 8'h40, 32'h5, 1, rd);
      do_read_const("name0_after_wr", A_NAME0, 32'h61707066);
      do_read_const("unmapped_rd", 8'h20, 32'h0);

      // Reset in the middle of a held DATA write with 5 words queued
      do_pop("pop_uf_pre", 1);
      for (int i = 0; i < 5; i++) do_push(32'hA000_0000 + 32'(i), 1);
      reset_n = 1'b0;
      bus_if.cs = 1'b1;
      bus_if.we = 1'b1;
      bus_if.address = A_DATA;
      bus_if.write_data = 32'hCAFE0001;
      @(posedge clk); #1;
      check("ready_in_rst", {31'b0, bus_if.ready}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", {31'b0, bus_if.ready}, 32'd1);
      @(posedge clk); #1;
      bus_if.cs = 1'b0;
      bus_if.we = 1'b0;
      @(posedge clk); #1;
      mq.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
      mq.push_back(32'hCAFE0001);
      do_read_const("status_post_rst", A_STATUS, 32'h00000100);
      do_pop("pop_post_rst", 1);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         op   = $urandom_range(0, 9);
         hold = $urandom_range(1, 3);
         case (op)
            0, 1, 2, 3: do_push($urandom, hold);
            4, 5, 6:    do_pop("rnd_pop", hold);
            7:          do_peek("rnd_peek", hold);
            8:          do_status("rnd_status", hold);
            default: begin
               if ($urandom_range(0, 4) == 0) begin
                  val = $urandom;
                  do_ctrl(val, hold);
               end else begin
                  access(1'b0, unmapped[$urandom_range(0, 3)], 32'h0, hold, rd);
                  check("rnd_unmapped", rd, 32'h0);
               end
            end
         endcase
      end
      do_status("final_status", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/app_fifo.md
# app_fifo

Memory-mapped 32-bit word FIFO core for the application FPGA MMIO space, used as a mailbox between firmware and application or as a staging buffer for streaming data. It sits downstream of the CPU memory decode/mux, on the standard core port (cs/we/address/write_data/read_data/ready), on a free MMIO core sub-prefix. It provides push/pop/peek registers, fill status and sticky error flags.

## Interface
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 words. Legal range 1..7.
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- cs  in  1  core select from the bus mux. Held high for consecutive cycles per access, then low for at least 1 cycle.
- we  in  1  write access when high with cs.
- address  in  8  word address (cpu_addr[9:2]).
- write_data  in  32  write data.
- read_data  out  32  registered read data.
- ready  out  1  access acknowledge, registered.

## Operation
- Register map (word addresses):
  - 0x00 NAME0, RO = 32'h61707066.
  - 0x01 VERSION, RO = 32'h00000001.
  - 0x08 CTRL, WO: bit0=1 flushes the FIFO (pointers, count, sticky flags to 0). Other bits ignored.
  - 0x09 STATUS, RO: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bits[15:8] count, other bits 0.
  - 0x10 DATA: a write pushes write_data. A read pops and returns the head word.
  - 0x11 PEEK, RO: returns the head word without popping.
  - Unmapped reads return 0. Unmapped writes and writes to RO registers have no effect.
- Access strobe: act = cs && !cs_reg, where cs_reg is cs delayed one cycle. All side effects (push, pop, flush) and read_data capture occur only on the act cycle. Repeated cs cycles within one access never repeat a side effect.
- Storage: 2^DEPTH_LOG2 x 32 register array. wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth. count is DEPTH_LOG2+1 bits, range 0..depth.
- Push when full: data is dropped, pointers are unchanged, overflow is set.
- Pop when empty: read_data = 0, pointers are unchanged, underflow is set.
- PEEK when empty: returns 0 and sets no flag.
- The bus allows only one access at a time, so a push and a pop never occur in the same cycle.
- Flush takes priority and completes on its act cycle. Array contents are not cleared.

## Timing
- Reset values: read_data=0, ready=0, cs_reg=0, wr_ptr=rd_ptr=0, count=0, overflow=underflow=0. STATUS therefore reads 0x00000001 after reset.
- ready_reg <= cs. ready is high in every cycle that follows a cs-high cycle, i.e. 1-cycle latency from cs.
- read_data is registered on the act cycle. It is valid when ready first rises and stays stable until the next act.
- Pop takes effect on the act cycle. A STATUS read in a following access reflects the new count.
- Push at act cycle N: the word is readable by a DATA/PEEK act at N+2 or later (the minimum bus spacing).
- Reset mid-access: all state returns to reset values on the next edge and ready drops. A subsequent cs-high cycle counts as a new act.
- STATUS full = (count == depth). STATUS empty = (count == 0).

## Test plan
- After reset: read NAME0 -> 0x61707066; VERSION -> 0x00000001; STATUS -> 0x00000001; ready rises exactly 1 cycle after cs.
- Push 0xDEADBEEF and 0x12345678 (hold cs 2 cycles each) -> STATUS count=2, not doubled. PEEK -> 0xDEADBEEF with count still 2. Two DATA reads -> 0xDEADBEEF then 0x12345678; STATUS -> 0x00000001.
- Push 17 words 0..16 at DEPTH_LOG2=4 -> STATUS = 0x00001006 (count 16, full, overflow). Pop 16 -> values 0..15 in order; word 16 is lost.
- Read DATA when empty -> 0x00000000 and STATUS = 0x00000009. Write CTRL=1 -> STATUS = 0x00000001.
- Wrap-around: 3 rounds of push-12/pop-12 -> order preserved across the pointer wrap, and no flags set.
- Assert reset_n=0 for 1 cycle while holding cs on a DATA write with 5 words queued -> count=0, ready=0, flags clear. After reset, the same held cs produces one push and count=1.
